// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order types: reservation-station entry and CDB broadcast payloads.
package rv32i_types;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned PHYS_REG_ADDR_WIDTH = 6;
  localparam int unsigned ROB_ID_WIDTH        = 4;
  localparam int unsigned ALU_OP_WIDTH        = 4;
  localparam int unsigned RS_DEPTH            = 4;

  // An operand's data field holds its physical-register tag in the low bits until ready.
  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0]        alu_op;
    logic [PHYS_REG_ADDR_WIDTH-1:0] rd_paddr;
    logic [ROB_ID_WIDTH-1:0]        rob_id;
    logic                           rs1_ready;
    logic [XLEN-1:0]                rs1_data;
    logic                           rs2_ready;
    logic [XLEN-1:0]                rs2_data;
  } rs_t;

  typedef struct packed {
    logic                           valid;
    logic                           rd_valid;
    logic [PHYS_REG_ADDR_WIDTH-1:0] rd_paddr;
    logic [XLEN-1:0]                rd_data;
  } cdb_t;

endpackage

// File: rtl/rs_wakeup.sv
// Single-operand CDB wakeup: captures broadcast data into a waiting operand whose tag matches.
module rs_wakeup
  import rv32i_types::*;
(
  input  logic            ready,
  input  logic [XLEN-1:0] data,
  input  cdb_t            cdb,
  output logic            ready_c,
  output logic [XLEN-1:0] data_c
);

  logic hit;

  // Ready operands hold real values, so a coincidental low-bit match must not overwrite them.
  assign hit = cdb.valid && cdb.rd_valid && !ready &&
               (data[PHYS_REG_ADDR_WIDTH-1:0] == cdb.rd_paddr);

  assign ready_c = ready | hit;
  assign data_c  = hit ? cdb.rd_data : data;

endmodule

// File: rtl/res_station.sv
// Age-ordered collapsing reservation station with CDB wakeup, oldest-ready issue and flush.
module res_station
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  rs_t                      enq_entry,
  output logic                     enq_ready,
  input  cdb_t                     cdb,
  input  logic                     flush,
  output logic                     iss_valid,
  output rs_t                      iss_entry,
  input  logic                     iss_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  rs_t              slots_q [DEPTH];
  rs_t              slots_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr_idx;

  // Index DEPTH of these arrays is the incoming enqueue entry.
  rs_t              src_entry [DEPTH+1];
  rs_t              woken     [DEPTH+1];
  logic [DEPTH:0]   w1_rdy;
  logic [DEPTH:0]   w2_rdy;
  logic [XLEN-1:0]  w1_data   [DEPTH+1];
  logic [XLEN-1:0]  w2_data   [DEPTH+1];

  logic             iss_any;
  logic [IW-1:0]    iss_idx;
  logic             fire;
  logic             enq_accept;

  // Wakeup compare for both operands of every slot plus the enqueue path.
  for (genvar g = 0; g <= DEPTH; g++) begin : g_wake
    if (g == DEPTH) begin : g_enq
      assign src_entry[g] = enq_entry;
    end else begin : g_slot
      assign src_entry[g] = slots_q[g];
    end

    rs_wakeup u_wake_rs1 (
      .ready   (src_entry[g].rs1_ready),
      .data    (src_entry[g].rs1_data),
      .cdb     (cdb),
      .ready_c (w1_rdy[g]),
      .data_c  (w1_data[g])
    );

    rs_wakeup u_wake_rs2 (
      .ready   (src_entry[g].rs2_ready),
      .data    (src_entry[g].rs2_data),
      .cdb     (cdb),
      .ready_c (w2_rdy[g]),
      .data_c  (w2_data[g])
    );
  end

  always_comb begin
    for (int i = 0; i <= int'(DEPTH); i++) begin
      woken[i]           = src_entry[i];
      woken[i].rs1_ready = w1_rdy[i];
      woken[i].rs1_data  = w1_data[i];
      woken[i].rs2_ready = w2_rdy[i];
      woken[i].rs2_data  = w2_data[i];
    end
  end

  // Oldest ready slot wins; only registered operand state counts, so CDB-to-issue is one cycle.
  always_comb begin
    iss_any = 1'b0;
    iss_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid_q[i] && slots_q[i].rs1_ready && slots_q[i].rs2_ready) begin
        iss_any = 1'b1;
        iss_idx = IW'(i);
      end
    end
  end

  assign iss_valid  = iss_any && !flush;
  assign iss_entry  = slots_q[iss_idx];
  assign fire       = iss_valid && iss_ready;
  assign enq_accept = enq_valid && enq_ready && !flush;
  assign wr_idx     = count_q - CW'(fire);

  // Collapse above the issued slot, carrying wakeup into the shifted copies, then append.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      slots_d[i] = woken[i];
      valid_d[i] = valid_q[i];
      if (fire && (IW'(i) >= iss_idx)) begin
        slots_d[i] = woken[i+1];
        if (i + 1 < int'(DEPTH)) begin
          valid_d[i] = valid_q[i+1];
        end else begin
          valid_d[i] = 1'b0;
        end
      end
      if (enq_accept && (CW'(i) == wr_idx)) begin
        slots_d[i] = woken[DEPTH];
        valid_d[i] = 1'b1;
      end
    end
    count_d = count_q + CW'(enq_accept) - CW'(fire);
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      count_q   <= '0;
      enq_ready <= 1'b1;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      enq_ready <= (count_d < CW'(DEPTH));
    end
  end

  // Payloads are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      slots_q[i] <= slots_d[i];
    end
  end

  assign count = count_q;

endmodule
